// File: rtl/iter_func_unit.sv
`default_nettype none
// ============================================================================
// Module   : iter_func_unit
// Purpose  : Per-thread functional unit with private register file, 1-cycle
//            ALU ops and an iterative restoring divider (DATA_W steps).
//            Optional macro FUNC_UNIT_SIGNED_DIV_EN selects signed division.
// Revision : 1.0 - initial release
// ============================================================================
module iter_func_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int SHAMT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [2:0]          type_instruction,
    input  logic [REG_AW-1:0]   regnum_1,
    input  logic [REG_AW-1:0]   regnum_2,
    input  logic [REG_AW-1:0]   dest_reg,
    input  logic [SHAMT_W-1:0]  shammt,
    input  logic [DATA_W-1:0]   init_reg_data [0:NUM_REGS-1],
    input  logic                is_active,
    output logic [DATA_W-1:0]   final_result,
    output logic                result_valid,
    output logic                busy,
    output logic                thread_complete
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_DIV_STEPS = CNT_W'(DATA_W);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_MUL  = 3'b010;
    localparam logic [2:0] c_OP_DIV  = 3'b011;
    localparam logic [2:0] c_OP_SLL  = 3'b100;
    localparam logic [2:0] c_OP_SRL  = 3'b101;
    localparam logic [2:0] c_OP_LOAD = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [REG_AW-1:0]      dest_q, dest_d;
    logic [SHAMT_W-1:0]     shamt_q, shamt_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      b_q, b_d;
    logic [DATA_W-1:0]      rem_q, rem_d;
    logic [DATA_W-1:0]      quo_q, quo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   neg_q, neg_d;
    logic [DATA_W-1:0]      regs_q [0:NUM_REGS-1];
    logic [DATA_W-1:0]      regs_d [0:NUM_REGS-1];
    logic [DATA_W-1:0]      final_result_q, final_result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   thread_complete_q, thread_complete_d;

    logic                   w_accept;
    logic                   w_shift_oob;
    logic [DATA_W-1:0]      w_rs1, w_rs2;
    logic [DATA_W-1:0]      w_dvd, w_dvs;
    logic                   w_neg;
    logic [DATA_W-1:0]      w_alu;
    logic [DATA_W:0]        w_rem_sh, w_diff;
    logic [DATA_W-1:0]      w_quot;

    assign instr_ready     = (state_q == S_IDLE) && !thread_complete_q;
    assign busy            = (state_q != S_IDLE);
    assign final_result    = final_result_q;
    assign result_valid    = result_valid_q;
    assign thread_complete = thread_complete_q;

    assign w_accept = instr_valid && instr_ready;
    assign w_rs1    = regs_q[regnum_1];
    assign w_rs2    = regs_q[regnum_2];

`ifdef FUNC_UNIT_SIGNED_DIV_EN
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction
    // Divide-by-zero keeps the all-ones quotient unnegated so it reads as -1.
    assign w_dvd = mag(w_rs1);
    assign w_dvs = mag(w_rs2);
    assign w_neg = (w_rs1[DATA_W-1] ^ w_rs2[DATA_W-1]) && (w_rs2 != '0);
`else
    assign w_dvd = w_rs1;
    assign w_dvs = w_rs2;
    assign w_neg = 1'b0;
`endif

    assign w_shift_oob = (int'({1'b0, shamt_q}) >= DATA_W);

    always_comb begin
        w_alu = '0;
        case (op_q)
            c_OP_ADD: w_alu = a_q + b_q;
            c_OP_SUB: w_alu = a_q - b_q;
            c_OP_MUL: w_alu = a_q * b_q;
            c_OP_SLL: w_alu = w_shift_oob ? '0 : (a_q << shamt_q);
            c_OP_SRL: w_alu = w_shift_oob ? '0 : (a_q >> shamt_q);
            default:  w_alu = '0;
        endcase
    end

    // Remainder needs one extra bit: shifted value can reach 2*divisor-1.
    assign w_rem_sh = {rem_q, quo_q[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, b_q};
    assign w_quot   = neg_q ? (~quo_q + 1'b1) : quo_q;

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        dest_d            = dest_q;
        shamt_d           = shamt_q;
        a_d               = a_q;
        b_d               = b_q;
        rem_d             = rem_q;
        quo_d             = quo_q;
        cnt_d             = cnt_q;
        neg_d             = neg_q;
        regs_d            = regs_q;
        final_result_d    = final_result_q;
        result_valid_d    = 1'b0;
        thread_complete_d = thread_complete_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept && is_active) begin
                    op_d    = type_instruction;
                    dest_d  = dest_reg;
                    shamt_d = shammt;
                    a_d     = w_rs1;
                    b_d     = w_rs2;
                    if (type_instruction == c_OP_DIV) begin
                        b_d     = w_dvs;
                        quo_d   = w_dvd;
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_d   = w_neg;
                        state_d = S_DIV;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (op_q == c_OP_LOAD) begin
                    regs_d = init_reg_data;
                end else if (op_q == 3'b111) begin
                    thread_complete_d = 1'b1;
                    state_d           = S_DONE;
                end else begin
                    regs_d[dest_q] = w_alu;
                    final_result_d = w_alu;
                    result_valid_d = 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q != c_DIV_STEPS) begin
                    if (!w_diff[DATA_W]) begin
                        rem_d = w_diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = w_rem_sh[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    regs_d[dest_q] = w_quot;
                    final_result_d = w_quot;
                    result_valid_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_IDLE;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            op_q              <= '0;
            dest_q            <= '0;
            shamt_q           <= '0;
            a_q               <= '0;
            b_q               <= '0;
            rem_q             <= '0;
            quo_q             <= '0;
            cnt_q             <= '0;
            neg_q             <= 1'b0;
            final_result_q    <= '0;
            result_valid_q    <= 1'b0;
            thread_complete_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q           <= state_d;
            op_q              <= op_d;
            dest_q            <= dest_d;
            shamt_q           <= shamt_d;
            a_q               <= a_d;
            b_q               <= b_d;
            rem_q             <= rem_d;
            quo_q             <= quo_d;
            cnt_q             <= cnt_d;
            neg_q             <= neg_d;
            final_result_q    <= final_result_d;
            result_valid_q    <= result_valid_d;
            thread_complete_q <= thread_complete_d;
            regs_q            <= regs_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_func_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_func_unit
// Purpose  : Directed self-checking bench for iter_func_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_func_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  type_instruction;
    logic [4:0]  regnum_1, regnum_2, dest_reg;
    logic [5:0]  shammt;
    logic [31:0] init_reg_data [0:31];
    logic        is_active;
    logic [31:0] final_result;
    logic        result_valid;
    logic        busy;
    logic        thread_complete;

    int passed = 0;
    int total  = 0;

    iter_func_unit dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .type_instruction(type_instruction),
        .regnum_1        (regnum_1),
        .regnum_2        (regnum_2),
        .dest_reg        (dest_reg),
        .shammt          (shammt),
        .init_reg_data   (init_reg_data),
        .is_active       (is_active),
        .final_result    (final_result),
        .result_valid    (result_valid),
        .busy            (busy),
        .thread_complete (thread_complete)
    );

    always #5 clk = ~clk;

    // Drives one instruction, returns #1 after its accept edge with valid low.
    task automatic send(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic [5:0] sh);
        @(negedge clk);
        type_instruction = op;
        regnum_1         = r1;
        regnum_2         = r2;
        dest_reg         = rd;
        shammt           = sh;
        instr_valid      = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Edges after the accept edge until result_valid is seen (-1 if never).
    task automatic wait_result(input int budget, output int lat, output logic [31:0] res,
                               output int busy_n);
        lat    = -1;
        res    = 'x;
        busy_n = busy ? 1 : 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = i;
                res = final_result;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({final_result, result_valid, busy, thread_complete} !== 35'd0) begin
            $display("FAIL reset_outputs: got res=%h vld=%b busy=%b tc=%b, want all 0",
                     final_result, result_valid, busy, thread_complete);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready);
        else passed++;
    endtask

    task automatic test_load_and_add();
        int lat, bn;
        logic [31:0] res;
        send(3'b110, 5'd0, 5'd0, 5'd0, 6'd0);
        wait_result(3, lat, res, bn);
        total++;
        if (lat != -1 || final_result !== 32'd0)
            $display("FAIL load_no_pulse: got lat=%0d res=%h want lat=-1 res=0", lat, final_result);
        else passed++;
        send(3'b000, 5'd2, 5'd4, 5'd5, 6'd0);
        total++;
        if (instr_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL add_exec_state: got rdy=%b busy=%b want 0/1", instr_ready, busy);
        else passed++;
        wait_result(4, lat, res, bn);
        total++;
        if (lat != 1 || res !== 32'd6)
            $display("FAIL add_result: got lat=%0d res=%h want lat=1 res=6", lat, res);
        else passed++;
        send(3'b000, 5'd5, 5'd0, 5'd20, 6'd0);
        wait_result(4, lat, res, bn);
        total++;
        if (res !== 32'd6) $display("FAIL r5_readback: got %h want 6", res);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [4:0]  r1s [4] = '{5'd7, 5'd10, 5'd3, 5'd0};
        logic [4:0]  r2s [4] = '{5'd6, 5'd11, 5'd0, 5'd1};
        logic [4:0]  rds [4] = '{5'd8, 5'd12, 5'd14, 5'd13};
        logic [5:0]  shs [4] = '{6'd0, 6'd0, 6'd4, 6'd0};
        logic [31:0] exps[4] = '{32'd1, 32'd110, 32'd48, 32'hFFFF_FFFF};
        int lat, bn;
        logic [31:0] res;
        @(negedge clk);
        type_instruction = ops[0]; regnum_1 = r1s[0]; regnum_2 = r2s[0];
        dest_reg = rds[0]; shammt = shs[0]; instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (instr_ready !== 1'b0) $display("FAIL b2b_ready_exec[%0d]: got %b want 0", k, instr_ready);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (result_valid !== 1'b1 || final_result !== exps[k])
                $display("FAIL b2b_result[%0d]: got vld=%b res=%h want 1/%h",
                         k, result_valid, final_result, exps[k]);
            else passed++;
            if (k < 3) begin
                type_instruction = ops[k+1]; regnum_1 = r1s[k+1]; regnum_2 = r2s[k+1];
                dest_reg = rds[k+1]; shammt = shs[k+1];
            end else instr_valid = 1'b0;
        end
        send(3'b000, 5'd8, 5'd12, 5'd21, 6'd0);
        wait_result(4, lat, res, bn);
        total++;
        if (res !== 32'd111) $display("FAIL b2b_writeback: got %h want 111", res);
        else passed++;
        send(3'b101, 5'd14, 5'd0, 5'd22, 6'd40);
        wait_result(4, lat, res, bn);
        total++;
        if (res !== 32'd0) $display("FAIL srl_oob: got %h want 0", res);
        else passed++;
    endtask

    task automatic test_divide();
        int lat, bn;
        logic [31:0] res;
        send(3'b011, 5'd31, 5'd3, 5'd16, 6'd0);
        wait_result(40, lat, res, bn);
        total++;
        if (lat != 33 || res !== 32'd10 || bn != 33)
            $display("FAIL div_31_3: got lat=%0d res=%h busy=%0d want 33/10/33", lat, res, bn);
        else passed++;
        send(3'b011, 5'd9, 5'd0, 5'd17, 6'd0);
        wait_result(40, lat, res, bn);
        total++;
        if (lat != 33 || res !== 32'hFFFF_FFFF)
            $display("FAIL div_by_zero: got lat=%0d res=%h want 33/ffffffff", lat, res);
        else passed++;
    endtask

    task automatic test_inactive();
        int lat, bn;
        logic [31:0] res;
        send(3'b001, 5'd5, 5'd5, 5'd5, 6'd0);
        wait_result(4, lat, res, bn);
        is_active = 1'b0;
        send(3'b000, 5'd2, 5'd4, 5'd5, 6'd0);
        total++;
        if (busy !== 1'b0 || instr_ready !== 1'b1)
            $display("FAIL inactive_idle: got busy=%b rdy=%b want 0/1", busy, instr_ready);
        else passed++;
        wait_result(4, lat, res, bn);
        total++;
        if (lat != -1) $display("FAIL inactive_pulse: got lat=%0d want -1", lat);
        else passed++;
        is_active = 1'b1;
        send(3'b000, 5'd5, 5'd0, 5'd23, 6'd0);
        wait_result(4, lat, res, bn);
        total++;
        if (res !== 32'd0) $display("FAIL inactive_r5: got %h want 0", res);
        else passed++;
    endtask

    task automatic test_reset_mid_divide();
        int lat, bn;
        logic [31:0] res;
        send(3'b011, 5'd31, 5'd3, 5'd18, 6'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({final_result, result_valid, busy, thread_complete} !== 35'd0)
            $display("FAIL async_reset: got res=%h vld=%b busy=%b tc=%b want all 0",
                     final_result, result_valid, busy, thread_complete);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        wait_result(40, lat, res, bn);
        total++;
        if (lat != -1) $display("FAIL reset_abort_pulse: got lat=%0d want -1", lat);
        else passed++;
        send(3'b000, 5'd31, 5'd3, 5'd1, 6'd0);
        wait_result(4, lat, res, bn);
        total++;
        if (res !== 32'd0) $display("FAIL reset_regs_cleared: got %h want 0", res);
        else passed++;
    endtask

`ifdef FUNC_UNIT_SIGNED_DIV_EN
    task automatic test_signed_div();
        int lat, bn;
        logic [31:0] res;
        init_reg_data[27] = 32'hFFFF_FFFF;
        init_reg_data[28] = 32'h8000_0000;
        init_reg_data[29] = 32'd2;
        init_reg_data[30] = 32'hFFFF_FFF9;
        send(3'b110, 5'd0, 5'd0, 5'd0, 6'd0);
        wait_result(3, lat, res, bn);
        send(3'b011, 5'd30, 5'd29, 5'd24, 6'd0);
        wait_result(40, lat, res, bn);
        total++;
        if (lat != 33 || res !== 32'hFFFF_FFFD)
            $display("FAIL sdiv_m7_2: got lat=%0d res=%h want 33/fffffffd", lat, res);
        else passed++;
        send(3'b011, 5'd28, 5'd27, 5'd25, 6'd0);
        wait_result(40, lat, res, bn);
        total++;
        if (res !== 32'h8000_0000) $display("FAIL sdiv_min_m1: got %h want 80000000", res);
        else passed++;
    endtask
`endif

    task automatic test_halt();
        int lat, bn;
        logic [31:0] res;
        send(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        total++;
        if (thread_complete !== 1'b0) $display("FAIL halt_early: got tc=%b want 0", thread_complete);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (thread_complete !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL halt_done: got tc=%b rdy=%b busy=%b want 1/0/1",
                     thread_complete, instr_ready, busy);
        else passed++;
        type_instruction = 3'b000; regnum_1 = 5'd2; regnum_2 = 5'd4; dest_reg = 5'd5;
        instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (instr_ready !== 1'b0 || result_valid !== 1'b0 || thread_complete !== 1'b1)
                $display("FAIL halt_hold[%0d]: got rdy=%b vld=%b tc=%b want 0/0/1",
                         k, instr_ready, result_valid, thread_complete);
            else passed++;
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        instr_valid = 1'b0; type_instruction = '0; regnum_1 = '0; regnum_2 = '0;
        dest_reg = '0; shammt = '0; is_active = 1'b1; rst = 1'b0;
        for (int i = 0; i < 32; i++) init_reg_data[i] = 32'(i);
        test_reset();
        test_load_and_add();
        test_back_to_back();
        test_divide();
        test_inactive();
        test_reset_mid_divide();
        send(3'b110, 5'd0, 5'd0, 5'd0, 6'd0);
        repeat (2) @(posedge clk);
`ifdef FUNC_UNIT_SIGNED_DIV_EN
        test_signed_div();
`endif
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
